// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO with occupancy count, almost-full/empty flags and optional fall-through read.
// Define SYNC_FIFO_LVL_ERR_EN to add sticky overflow (ovf) / underflow (udf) outputs.
module sync_fifo_lvl #(
    parameter int DATA_BITS       = 8,
    parameter int FIFO_DEPTH_BITS = 3,
    parameter int AFULL_THRESH    = 6,
    parameter int AEMPTY_THRESH   = 1,
    parameter int FWFT            = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [DATA_BITS-1:0]       dataIn,
    input  logic                       re,
    output logic [DATA_BITS-1:0]       dataOut,
    output logic                       wfull,
    output logic                       rempty,
    output logic                       afull,
    output logic                       aempty,
    output logic [FIFO_DEPTH_BITS:0]   level
`ifdef SYNC_FIFO_LVL_ERR_EN
    ,
    output logic                       ovf,
    output logic                       udf
`endif
);
    localparam int PW    = FIFO_DEPTH_BITS + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam logic [PW-1:0] DEPTH_L  = DEPTH[PW-1:0];
    localparam logic [PW-1:0] AFULL_L  = AFULL_THRESH[PW-1:0];
    localparam logic [PW-1:0] AEMPTY_L = AEMPTY_THRESH[PW-1:0];

    logic [DATA_BITS-1:0] mem [DEPTH];

    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
    logic          wfull_q, wfull_d, rempty_q, rempty_d;
    logic          afull_q, afull_d, aempty_q, aempty_d;
    logic          wacc, racc;
    logic [FIFO_DEPTH_BITS-1:0] waddr, raddr;

    assign waddr = wptr_q[FIFO_DEPTH_BITS-1:0];
    assign raddr = rptr_q[FIFO_DEPTH_BITS-1:0];

    // A read of a full FIFO frees the slot the same-cycle write lands in.
    assign racc = re & ~rempty_q;
    assign wacc = we & (~wfull_q | racc);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (wacc) wptr_d = wptr_q + 1'b1;
        if (racc) rptr_d = rptr_q + 1'b1;
        if (wacc && !racc)      level_d = level_q + 1'b1;
        else if (racc && !wacc) level_d = level_q - 1'b1;
        wfull_d  = (level_d == DEPTH_L);
        rempty_d = (level_d == '0);
        afull_d  = (level_d >= AFULL_L);
        aempty_d = (level_d <= AEMPTY_L);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            wfull_q  <= 1'b0;
            rempty_q <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            wfull_q  <= wfull_d;
            rempty_q <= rempty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wacc) mem[waddr] <= dataIn;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown while non-empty; zero otherwise keeps reset output clean.
            assign dataOut = rempty_q ? '0 : mem[raddr];
        end else begin : g_reg_read
            logic [DATA_BITS-1:0] dout_q, dout_d;
            always_comb begin
                dout_d = dout_q;
                if (racc) dout_d = mem[raddr];
            end
            always_ff @(posedge clk) begin
                if (rst) dout_q <= '0;
                else     dout_q <= dout_d;
            end
            assign dataOut = dout_q;
        end
    endgenerate

    assign wfull  = wfull_q;
    assign rempty = rempty_q;
    assign afull  = afull_q;
    assign aempty = aempty_q;
    assign level  = level_q;

`ifdef SYNC_FIFO_LVL_ERR_EN
    logic ovf_q, ovf_d, udf_q, udf_d;
    always_comb begin
        ovf_d = ovf_q | (we & ~wacc);
        udf_d = udf_q | (re & rempty_q);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end
    assign ovf = ovf_q;
    assign udf = udf_q;
`endif
endmodule
